// File: rtl/spi_target.sv
`timescale 1ns/1ps
// spi_target -- SPI mode-0 target (CPOL=0, CPHA=0), MSB first, full duplex.
//
// The block samples sclk, cs_n and mosi on the system clock. MOSI bytes are
// delivered on a valid/ready receive stream. MISO bytes are taken from a
// valid/ready transmit stream. When no transmit byte is available, FILL is
// sent instead.
//
// Parameters:
//   FILL  byte shifted out on MISO when no transmit data is available
//   SYNC  synchroniser depth for sclk/cs_n/mosi (minimum 2)
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sclk, cs_n, mosi   SPI pins from the controller (asynchronous to clk)
//   miso               target-to-controller data; 0 while deselected
//   tx_valid/tx_ready/tx_data   transmit stream; tx_ready pulses on consume
//   rx_valid/rx_ready/rx_data   receive stream; one byte of holding storage
//   busy               synchronised chip select is asserted
//
// Optional build macro SPI_TARGET_ERR_EN adds err_clr (in), and the sticky
// error flags err_overrun and err_underrun (out).
module spi_target #(
  parameter logic [7:0] FILL = 8'hFF,
  parameter int         SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       busy
`ifdef SPI_TARGET_ERR_EN
  ,
  input  logic       err_clr,
  output logic       err_overrun,
  output logic       err_underrun
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_reg, state_next;

  // sclk/cs_n carry one extra stage so edges compare the last two
  // synchronised samples. mosi only needs to line up with the sclk sample.
  logic [SYNC:0]   sclk_pipe;
  logic [SYNC:0]   cs_pipe;
  logic [SYNC-1:0] mosi_pipe;

  logic [2:0] bit_cnt_reg;
  logic [7:0] tx_sr_reg;
  logic [7:0] rx_sr_reg;
  logic [7:0] rx_shift;

  logic rise, fall, cs_fall, cs_rise, mosi_s;
  logic load_tx, shift_tx, sample_rx, cs_abort, byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;   // deselected, so reset never looks like a cs_fall
      mosi_pipe <= '0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC-1:0], sclk};
      cs_pipe   <= {cs_pipe[SYNC-1:0], cs_n};
      mosi_pipe <= {mosi_pipe[SYNC-2:0], mosi};
    end
  end

  assign rise    =  sclk_pipe[SYNC-1] & ~sclk_pipe[SYNC];
  assign fall    = ~sclk_pipe[SYNC-1] &  sclk_pipe[SYNC];
  assign cs_fall = ~cs_pipe[SYNC-1]   &  cs_pipe[SYNC];
  assign cs_rise =  cs_pipe[SYNC-1]   & ~cs_pipe[SYNC];
  assign mosi_s  =  mosi_pipe[SYNC-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode. Deselection has priority over any sclk edge
  // that is detected in the same cycle.
  always_comb begin
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    cs_abort  = 1'b0;
    if (state_reg == IDLE) begin
      load_tx = cs_fall;
    end else if (cs_rise) begin
      cs_abort = 1'b1;
    end else begin
      if (fall) begin
        if (bit_cnt_reg == 3'd0) load_tx  = 1'b1;
        else                     shift_tx = 1'b1;
      end
      sample_rx = rise;
    end
    tx_ready = load_tx & tx_valid;
    miso     = (state_reg == ACTIVE) & tx_sr_reg[7];
    busy     = ~cs_pipe[SYNC-1];
  end

  assign rx_shift  = {rx_sr_reg[6:0], mosi_s};
  assign byte_done = sample_rx & (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      bit_cnt_reg <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      if (load_tx)       tx_sr_reg <= tx_valid ? tx_data : FILL;
      else if (shift_tx) tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};

      // A new window or an aborted one restarts at bit 0; any partial
      // receive byte is abandoned because bit_cnt no longer reaches 7.
      if (load_tx && state_reg == IDLE || cs_abort) begin
        bit_cnt_reg <= '0;
      end else if (sample_rx) begin
        rx_sr_reg   <= rx_shift;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      // A byte completing while the held byte is being accepted replaces it
      // directly; if the held byte is not being accepted the new one is lost.
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_TARGET_ERR_EN
  logic overrun, underrun;
  assign overrun  = byte_done & rx_valid & ~rx_ready;
  assign underrun = load_tx & ~tx_valid;

  // A set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (overrun)      err_overrun  <= 1'b1;
      else if (err_clr) err_overrun  <= 1'b0;
      if (underrun)     err_underrun <= 1'b1;
      else if (err_clr) err_underrun <= 1'b0;
    end
  end
`endif

endmodule
